// File: rtl/irq_req_latch_if.sv
// Request/ack/eoi bundle between the interrupt source latch and its consumer.
// master drives requests and handshakes; slave is the latch itself.
interface irq_req_latch_if;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] ack_idx;
    logic       eoi;
    logic       ovf_clr;
    logic [7:0] d_out;
    logic       irq;
    logic       busy;
    logic [2:0] insvc_idx;
    logic [7:0] ovf;
    logic       ack_err;

    modport master (
        output req_in, mask, ack, ack_idx, eoi, ovf_clr,
        input  d_out, irq, busy, insvc_idx, ovf, ack_err
    );

    modport slave (
        input  req_in, mask, ack, ack_idx, eoi, ovf_clr,
        output d_out, irq, busy, insvc_idx, ovf, ack_err
    );
endinterface

// File: rtl/irq_req_latch.sv
// Edge-latched 8-line interrupt pending register with ack/eoi service FSM.
// Latency: d_out one edge after a rising request, irq one edge later; no backpressure, ack is a single-cycle strobe.
module irq_req_latch (
    input  logic            clk,
    input  logic            rst,
    irq_req_latch_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state;
    logic [7:0] req_d;
    logic [7:0] pend;
    logic [7:0] ovf;
    logic       irq;
    logic       busy;
    logic       ack_err;
    logic [2:0] insvc_idx;

    logic [7:0] rise;
    logic [7:0] d_out;
    logic [7:0] clr_vec;
    logic [7:0] ovf_set;
    logic       ack_ok;

    assign rise    = bus.req_in & ~req_d;
    assign d_out   = pend & ~bus.mask;
    assign ack_ok  = (state == REQ) && bus.ack && d_out[bus.ack_idx];
    assign clr_vec = ack_ok ? (8'h01 << bus.ack_idx) : 8'h00;
    // A line accepted this cycle cannot overflow even if it rises again.
    assign ovf_set = rise & pend & ~clr_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_d     <= 8'h00;
            pend      <= 8'h00;
            ovf       <= 8'h00;
            irq       <= 1'b0;
            busy      <= 1'b0;
            ack_err   <= 1'b0;
            insvc_idx <= 3'd0;
        end else begin
            req_d <= bus.req_in;
            // Set wins over the ack clear on the same line.
            pend  <= (pend & ~clr_vec) | rise;
            ovf   <= (bus.ovf_clr ? 8'h00 : ovf) | ovf_set;

            case (state)
                IDLE: begin
                    if (|d_out) begin
                        state <= REQ;
                        irq   <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        irq <= 1'b0;
                        if (ack_ok) begin
                            state     <= SERVICE;
                            busy      <= 1'b1;
                            insvc_idx <= bus.ack_idx;
                        end else begin
                            state   <= IDLE;
                            ack_err <= 1'b1;
                        end
                    end else if (d_out == 8'h00) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d_out     = d_out;
    assign bus.irq       = irq;
    assign bus.busy      = busy;
    assign bus.insvc_idx = insvc_idx;
    assign bus.ovf       = ovf;
    assign bus.ack_err   = ack_err;
endmodule

// File: tb/tb_irq_req_latch.sv
// Bench for irq_req_latch: directed scenarios with fixed expectations, then random traffic against a line-level model.
module tb_irq_req_latch;
    logic clk;
    logic rst;
    irq_req_latch_if bus ();

    irq_req_latch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: what is latched per line, and whether the consumer is being asked / serving.
    localparam int M_IDLE  = 0;
    localparam int M_ASK   = 1;
    localparam int M_SERVE = 2;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_ovf  = 8'h00;
    logic       m_err  = 1'b0;
    logic [2:0] m_idx  = 3'd0;
    int         m_mode = M_IDLE;

    function automatic logic [21:0] obs();
        return {bus.d_out, bus.irq, bus.busy, bus.insvc_idx, bus.ovf, bus.ack_err};
    endfunction

    function automatic logic [21:0] pk(logic [7:0] d, logic i, logic b, logic [2:0] x,
                                       logic [7:0] o, logic e);
        return {d, i, b, x, o, e};
    endfunction

    task automatic tick();
        logic [7:0] rise;
        logic [7:0] vis;
        logic       take;
        rise = bus.req_in & ~m_last;
        vis  = m_pend & ~bus.mask;
        if (rst) begin
            m_pend = 8'h00; m_last = 8'h00; m_ovf = 8'h00;
            m_err  = 1'b0;  m_idx  = 3'd0;  m_mode = M_IDLE;
        end else begin
            take = (m_mode == M_ASK) && bus.ack && vis[bus.ack_idx];
            if (bus.ovf_clr) m_ovf = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (rise[i] && m_pend[i] && !(take && bus.ack_idx == i)) m_ovf[i] = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                if (take && bus.ack_idx == i) m_pend[i] = 1'b0;
                if (rise[i]) m_pend[i] = 1'b1;
            end
            m_last = bus.req_in;
            case (m_mode)
                M_IDLE: if (vis != 8'h00) m_mode = M_ASK;
                M_ASK: begin
                    if (bus.ack) begin
                        if (take) begin m_mode = M_SERVE; m_idx = bus.ack_idx; end
                        else begin m_err = 1'b1; m_mode = M_IDLE; end
                    end else if (vis == 8'h00) m_mode = M_IDLE;
                end
                default: if (bus.eoi) m_mode = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_in = 8'h00; bus.mask = 8'h00; bus.ack = 1'b0; bus.ack_idx = 3'd0;
        bus.eoi = 1'b0; bus.ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] exp;
        clear_inputs();
        rst = 1'b1;
        tick();
        exp = pk(8'h00, 0, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL reset_state got %h want %h", obs(), exp); end
        rst = 1'b0; bus.ack = 1'b1; bus.ack_idx = 3'd3; bus.eoi = 1'b1; bus.ovf_clr = 1'b1;
        tick();
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL idle_ignores_ack_eoi got %h want %h", obs(), exp); end
        clear_inputs();
        bus.req_in = 8'hff; rst = 1'b1;
        tick();
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL reset_held_req got %h want %h", obs(), exp); end
        rst = 1'b0;
        tick();
        exp = pk(8'hff, 0, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL release_edge got %h want %h", obs(), exp); end
    endtask

    task automatic test_basic();
        logic [21:0] exp;
        do_reset();
        bus.req_in = 8'h20; tick();
        exp = pk(8'h20, 0, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL basic_dout got %h want %h", obs(), exp); end
        bus.req_in = 8'h00; tick();
        exp = pk(8'h20, 1, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL basic_irq got %h want %h", obs(), exp); end
        bus.ack = 1'b1; bus.ack_idx = 3'd5; tick();
        exp = pk(8'h00, 0, 1, 3'd5, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL basic_ack got %h want %h", obs(), exp); end
        bus.ack = 1'b0; bus.eoi = 1'b1; tick();
        exp = pk(8'h00, 0, 0, 3'd5, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL basic_eoi got %h want %h", obs(), exp); end
        bus.eoi = 1'b0;
    endtask

    task automatic test_priority_feed();
        logic [21:0] exp;
        do_reset();
        bus.req_in = 8'h81; tick();
        bus.req_in = 8'h00; tick();
        exp = pk(8'h81, 1, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL prio_irq got %h want %h", obs(), exp); end
        bus.ack = 1'b1; bus.ack_idx = 3'd7; tick();
        exp = pk(8'h01, 0, 1, 3'd7, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL prio_svc7 got %h want %h", obs(), exp); end
        bus.ack = 1'b0; bus.eoi = 1'b1; tick();
        exp = pk(8'h01, 0, 0, 3'd7, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL prio_idle_gap got %h want %h", obs(), exp); end
        bus.eoi = 1'b0; tick();
        exp = pk(8'h01, 1, 0, 3'd7, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL prio_reassert got %h want %h", obs(), exp); end
        bus.ack = 1'b1; bus.ack_idx = 3'd0; tick();
        exp = pk(8'h00, 0, 1, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL prio_svc0 got %h want %h", obs(), exp); end
        bus.ack = 1'b0;
    endtask

    task automatic test_overflow();
        logic [21:0] exp;
        do_reset();
        bus.req_in = 8'h08; tick();
        bus.req_in = 8'h00; tick();
        bus.req_in = 8'h08; tick();
        exp = pk(8'h08, 1, 0, 3'd0, 8'h08, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL ovf_set got %h want %h", obs(), exp); end
        bus.req_in = 8'h00; tick();
        bus.req_in = 8'h08; bus.ovf_clr = 1'b1; tick();
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL ovf_clr_vs_new got %h want %h", obs(), exp); end
        bus.req_in = 8'h00; bus.ovf_clr = 1'b0; tick();
        bus.ovf_clr = 1'b1; tick();
        exp = pk(8'h08, 1, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL ovf_clr got %h want %h", obs(), exp); end
        bus.ovf_clr = 1'b0;
    endtask

    task automatic test_mask_error();
        logic [21:0] exp;
        do_reset();
        bus.req_in = 8'h04; tick();
        bus.req_in = 8'h00; tick();
        bus.mask = 8'h04; #1;
        exp = pk(8'h00, 1, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL mask_comb got %h want %h", obs(), exp); end
        tick();
        exp = pk(8'h00, 0, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL mask_to_idle got %h want %h", obs(), exp); end
        bus.mask = 8'h00; tick();
        bus.ack = 1'b1; bus.ack_idx = 3'd1; tick();
        exp = pk(8'h04, 0, 0, 3'd0, 8'h00, 1);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL ack_err got %h want %h", obs(), exp); end
        bus.ack = 1'b0; tick();
        exp = pk(8'h04, 1, 0, 3'd0, 8'h00, 1);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL ack_err_sticky got %h want %h", obs(), exp); end
    endtask

    task automatic test_reset_mid_service();
        logic [21:0] exp;
        do_reset();
        bus.req_in = 8'h10; tick();
        bus.req_in = 8'h00; tick();
        bus.ack = 1'b1; bus.ack_idx = 3'd4; tick();
        bus.ack = 1'b0; bus.req_in = 8'h10; tick();
        exp = pk(8'h10, 0, 1, 3'd4, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL svc_accumulate got %h want %h", obs(), exp); end
        bus.req_in = 8'h01; rst = 1'b1; tick();
        exp = pk(8'h00, 0, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL rst_mid_svc got %h want %h", obs(), exp); end
        rst = 1'b0; tick();
        exp = pk(8'h01, 0, 0, 3'd0, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL rst_release_edge got %h want %h", obs(), exp); end
        bus.req_in = 8'h00;
    endtask

    task automatic test_set_clear();
        logic [21:0] exp;
        do_reset();
        bus.req_in = 8'h02; tick();
        bus.req_in = 8'h00; tick();
        bus.req_in = 8'h02; bus.ack = 1'b1; bus.ack_idx = 3'd1; tick();
        exp = pk(8'h02, 0, 1, 3'd1, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL set_wins got %h want %h", obs(), exp); end
        bus.req_in = 8'h00; bus.ack = 1'b0; bus.eoi = 1'b1; tick();
        bus.eoi = 1'b0; tick();
        exp = pk(8'h02, 1, 0, 3'd1, 8'h00, 0);
        n_cmp++; if (obs() !== exp) begin n_bad++; $display("FAIL set_wins_reask got %h want %h", obs(), exp); end
    endtask

    task automatic test_random();
        logic [21:0] exp;
        int bad_here;
        bad_here = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst         = ($urandom_range(0, 149) == 0);
            bus.req_in  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            bus.mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            bus.ack     = ($urandom_range(0, 2) == 0);
            bus.ack_idx = 3'($urandom_range(0, 7));
            bus.eoi     = ($urandom_range(0, 3) == 0);
            bus.ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
            exp = pk(m_pend & ~bus.mask, m_mode == M_ASK, m_mode == M_SERVE, m_idx, m_ovf, m_err);
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                if (bad_here < 10) $display("FAIL random_cycle_%0d got %h want %h", c, obs(), exp);
                bad_here++;
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_priority_feed();
        test_overflow();
        test_mask_error();
        test_reset_mid_service();
        test_set_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
